// File: rtl/param_serializer_if.sv
// param_serializer_if
//   Groups the parallel-load handshake and the serial output of
//   param_serializer into one bundle.
//
//   Signals (direction seen from the serializer, i.e. the slave):
//     p_data      in   DATA_WIDTH  parallel word, sampled on an accepted load
//     load        in   1           load request
//     ser_en      in   1           shift enable (0 freezes the active frame)
//     load_ready  out  1           holding buffer empty, a load will be taken
//     ser_data    out  1           serial bit
//     ser_valid   out  1           ser_data carries a data bit
//     ser_last    out  1           ser_data carries the final bit of a frame
//     ser_done    out  1           one-cycle pulse after the final bit
//     busy        out  1           frame active or word held
//     fsm_state   out  1           debug view of the FSM (0 = IDLE, 1 = SHIFT)
//
//   Modports: master (the TX sequencer driving loads), slave (the serializer).
interface param_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  load;
    logic                  ser_en;
    logic                  load_ready;
    logic                  ser_data;
    logic                  ser_valid;
    logic                  ser_last;
    logic                  ser_done;
    logic                  busy;
    logic                  fsm_state;

    modport master (
        output p_data, load, ser_en,
        input  load_ready, ser_data, ser_valid, ser_last, ser_done, busy,
               fsm_state
    );

    modport slave (
        input  p_data, load, ser_en,
        output load_ready, ser_data, ser_valid, ser_last, ser_done, busy,
               fsm_state
    );
endinterface

// File: rtl/param_serializer.sv
// param_serializer
//   Parametrised parallel-to-serial converter with a one-deep holding
//   buffer so consecutive frames leave back-to-back with no gap bit.
//
//   Parameters:
//     DATA_WIDTH  bits per frame (2 or more)
//     MSB_FIRST   0: bit 0 goes out first, 1: bit DATA_WIDTH-1 goes out first
//     IDLE_BIT    level on ser_data while no frame is active
//
//   Ports:
//     clk   in   single clock
//     rst   in   asynchronous, active-low reset
//     bus   slave side of param_serializer_if (handshake + serial output)
//
//   Handshake: a load is accepted on a rising edge where load=1 and
//   load_ready=1; p_data is sampled only on that edge. ser_data is a data
//   bit whenever ser_valid=1; it is consumed on each edge where ser_en=1.
//   No output depends combinationally on load, ser_en or p_data.
module param_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    param_serializer_if.slave   bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] sreg_shift;
    logic [DATA_WIDTH-1:0] hbuf;
    logic [CW-1:0]         cnt;
    logic                  hvalid;
    logic                  done_q;

    logic in_shift;
    logic frame_end;
    logic load_acc;
    logic data_o;
    logic valid_o;
    logic last_o;

    assign in_shift  = (state == SHIFT);
    // Frame end: the final bit is on the line and is being consumed now.
    assign frame_end = in_shift && bus.ser_en && (cnt == CNT_LAST);
    assign load_acc  = bus.load && !hvalid;

    // Move the next bit toward whichever end drives ser_data.
    assign sreg_shift = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_acc) state_nxt = SHIFT;
            // Stay in SHIFT if a held word or a bypass load chains the next frame.
            SHIFT:   if (frame_end && !hvalid && !bus.load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        data_o  = IDLE_BIT;
        valid_o = 1'b0;
        last_o  = 1'b0;
        if (in_shift) begin
            data_o  = MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0];
            valid_o = 1'b1;
            last_o  = (cnt == CNT_LAST);
        end
    end

    // Datapath: shift register, bit counter, holding buffer, done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg   <= '0;
            cnt    <= '0;
            hbuf   <= '0;
            hvalid <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= frame_end;
            case (state)
                IDLE: begin
                    if (load_acc) begin
                        sreg <= bus.p_data;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (frame_end) begin
                        // Held word wins; a coincident load is refused since
                        // load_ready is low whenever hvalid is set.
                        if (hvalid) begin
                            sreg   <= hbuf;
                            hvalid <= 1'b0;
                            cnt    <= '0;
                        end else if (bus.load) begin
                            sreg <= bus.p_data;
                            cnt  <= '0;
                        end
                    end else begin
                        if (bus.ser_en) begin
                            sreg <= sreg_shift;
                            cnt  <= cnt + CW'(1);
                        end
                        if (load_acc) begin
                            hbuf   <= bus.p_data;
                            hvalid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ser_data   = data_o;
    assign bus.ser_valid  = valid_o;
    assign bus.ser_last   = last_o;
    assign bus.ser_done   = done_q;
    assign bus.busy       = in_shift || hvalid;
    assign bus.load_ready = !hvalid;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_param_serializer.sv
// tb_param_serializer
//   Directed bench for param_serializer. Four instances cover the
//   configurations of interest: W=8 LSB-first idle-0, W=8 MSB-first idle-1,
//   W=2 and W=16. Inputs change 1 ns after a rising edge and outputs are
//   sampled at that same point, so "cycle c" below means the clock period
//   that follows the c-th edge after the load edge.
module tb_param_serializer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    param_serializer_if #(.DATA_WIDTH(8))  if8  ();
    param_serializer_if #(.DATA_WIDTH(8))  if8m ();
    param_serializer_if #(.DATA_WIDTH(2))  if2  ();
    param_serializer_if #(.DATA_WIDTH(16)) if16 ();

    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u8 (
        .clk(clk), .rst(rst), .bus(if8)
    );
    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u8m (
        .clk(clk), .rst(rst), .bus(if8m)
    );
    param_serializer #(.DATA_WIDTH(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u2 (
        .clk(clk), .rst(rst), .bus(if2)
    );
    param_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u16 (
        .clk(clk), .rst(rst), .bus(if16)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        tick;
        if8.load = 1'b1;  if8.ser_en = 1'b1;  if8.p_data = 8'hFF;
        if8m.load = 1'b1; if8m.ser_en = 1'b1; if8m.p_data = 8'hFF;
        if2.load = 1'b1;  if2.ser_en = 1'b1;  if2.p_data = 2'b11;
        if16.load = 1'b1; if16.ser_en = 1'b1; if16.p_data = 16'hFFFF;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
                   if8.busy, if8.load_ready, if8.fsm_state};
            checks++;
            if (got !== 7'b0000010) begin
                errors++;
                $display("FAIL reset_u8 i=%0d got=%b exp=%b", i, got, 7'b0000010);
            end
            got = {if8m.ser_data, if8m.ser_valid, if8m.ser_last, if8m.ser_done,
                   if8m.busy, if8m.load_ready, if8m.fsm_state};
            checks++;
            if (got !== 7'b1000010) begin
                errors++;
                $display("FAIL reset_u8m i=%0d got=%b exp=%b", i, got, 7'b1000010);
            end
            got = {if2.ser_valid, if16.ser_valid, if2.busy, if16.busy,
                   if2.load_ready, if16.load_ready, if2.ser_data};
            checks++;
            if (got !== 7'b0000110) begin
                errors++;
                $display("FAIL reset_w2_w16 i=%0d got=%b exp=%b", i, got, 7'b0000110);
            end
            tick;
        end
        if8.load = 1'b0;  if8.ser_en = 1'b0;
        if8m.load = 1'b0; if8m.ser_en = 1'b0;
        if2.load = 1'b0;  if2.ser_en = 1'b0;
        if16.load = 1'b0; if16.ser_en = 1'b0;
        rst = 1'b1;
        tick;
        got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
               if8.busy, if8.load_ready, if8.fsm_state};
        checks++;
        if (got !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, 7'b0000010);
        end
    endtask

    task automatic test_lsb_frame;
        logic [7:0] w;
        logic [5:0] got;
        logic [5:0] exp;
        w = 8'b10011011;
        if8.p_data = w; if8.load = 1'b1; if8.ser_en = 1'b1;
        tick;
        if8.load = 1'b0; if8.p_data = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            exp[5] = (c <= 8) ? w[c-1] : 1'b0;
            exp[4] = (c <= 8);
            exp[3] = (c == 8);
            exp[2] = (c == 9);
            exp[1] = (c <= 8);
            exp[0] = 1'b1;
            got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
                   if8.busy, if8.load_ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lsb_frame c=%0d got=%b exp=%b", c, got, exp);
            end
            tick;
        end
        if8.ser_en = 1'b0;
    endtask

    task automatic test_msb_stall;
        logic [7:0] w;
        logic [4:0] got;
        logic [4:0] exp;
        int         b;
        w = 8'b10011011;
        checks++;
        if (if8m.ser_data !== 1'b1) begin
            errors++;
            $display("FAIL msb_idle_level got=%b exp=1", if8m.ser_data);
        end
        if8m.p_data = w; if8m.load = 1'b1; if8m.ser_en = 1'b1;
        tick;
        if8m.load = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 3)      b = c - 1;
            else if (c <= 5) b = 2;
            else             b = c - 3;
            exp[4] = (c <= 10) ? w[7-b] : 1'b1;
            exp[3] = (c <= 10);
            exp[2] = (c == 10);
            exp[1] = (c == 11);
            exp[0] = (c <= 10);
            got = {if8m.ser_data, if8m.ser_valid, if8m.ser_last, if8m.ser_done,
                   if8m.busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL msb_stall c=%0d got=%b exp=%b", c, got, exp);
            end
            if8m.ser_en = !(c == 3 || c == 4);
            tick;
        end
        if8m.ser_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [5:0] got;
        logic [5:0] exp;
        w1 = 8'hA5;
        w2 = 8'h3C;
        if8.p_data = w1; if8.load = 1'b1; if8.ser_en = 1'b1;
        tick;
        if8.load = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 8)       exp[5] = w1[c-1];
            else if (c <= 16) exp[5] = w2[c-9];
            else              exp[5] = 1'b0;
            exp[4] = (c <= 16);
            exp[3] = (c == 8 || c == 16);
            exp[2] = (c == 9 || c == 17);
            exp[1] = (c <= 16);
            exp[0] = !(c >= 3 && c <= 8);
            got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
                   if8.busy, if8.load_ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, got, exp);
            end
            if8.load   = (c == 2);
            if8.p_data = (c == 2) ? w2 : 8'h00;
            tick;
        end
        if8.ser_en = 1'b0;
    endtask

    task automatic test_simultaneous;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [5:0] got;
        logic [5:0] exp;
        for (int v = 0; v < 2; v++) begin
            // v=0: load arrives on the frame-end edge with nothing held (bypass).
            // v=1: a word is held and a second load on the frame-end edge is dropped.
            w1 = (v == 0) ? 8'h5A : 8'h81;
            w2 = (v == 0) ? 8'hC3 : 8'h42;
            if8.p_data = w1; if8.load = 1'b1; if8.ser_en = 1'b1;
            tick;
            if8.load = 1'b0;
            for (int c = 1; c <= 18; c++) begin
                if (c <= 8)       exp[5] = w1[c-1];
                else if (c <= 16) exp[5] = w2[c-9];
                else              exp[5] = 1'b0;
                exp[4] = (c <= 16);
                exp[3] = (c == 8 || c == 16);
                exp[2] = (c == 9 || c == 17);
                exp[1] = (c <= 16);
                exp[0] = (v == 0) ? 1'b1 : !(c >= 3 && c <= 8);
                got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
                       if8.busy, if8.load_ready};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL simultaneous v=%0d c=%0d got=%b exp=%b", v, c, got, exp);
                end
                if (v == 0) begin
                    if8.load   = (c == 8);
                    if8.p_data = (c == 8) ? w2 : 8'h00;
                end else begin
                    if8.load   = (c == 2 || c == 8);
                    if8.p_data = (c == 2) ? w2 : ((c == 8) ? 8'hFF : 8'h00);
                end
                tick;
            end
        end
        if8.ser_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] w;
        logic [6:0] got;
        logic [6:0] exp;
        logic [2:0] g3;
        w = 8'h1F;
        if8.p_data = w; if8.load = 1'b1; if8.ser_en = 1'b1;
        tick;
        if8.load = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            exp = {w[c-1], 1'b1, 1'b0, 1'b0, 1'b1, (c <= 2), 1'b1};
            got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
                   if8.busy, if8.load_ready, if8.fsm_state};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid_pre c=%0d got=%b exp=%b", c, got, exp);
            end
            if8.load   = (c == 2);
            if8.p_data = (c == 2) ? 8'h66 : 8'h00;
            if (c < 5) tick;
        end
        rst = 1'b0;
        #1;
        got = {if8.ser_data, if8.ser_valid, if8.ser_last, if8.ser_done,
               if8.busy, if8.load_ready, if8.fsm_state};
        checks++;
        if (got !== 7'b0000010) begin
            errors++;
            $display("FAIL rst_mid_immediate got=%b exp=%b", got, 7'b0000010);
        end
        tick;
        tick;
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            g3 = {if8.ser_valid, if8.ser_done, if8.busy};
            checks++;
            if (g3 !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid_after c=%0d got=%b exp=000", c, g3);
            end
        end
        if8.ser_en = 1'b0;
    endtask

    task automatic test_width_sweep;
        logic [1:0]  w2;
        logic [15:0] w16;
        logic [4:0]  got;
        logic [4:0]  exp;
        w2 = 2'b10;
        if2.p_data = w2; if2.load = 1'b1; if2.ser_en = 1'b1;
        tick;
        if2.load = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp[4] = (c <= 2) ? w2[c-1] : 1'b0;
            exp[3] = (c <= 2);
            exp[2] = (c == 2);
            exp[1] = (c == 3);
            exp[0] = (c <= 2);
            got = {if2.ser_data, if2.ser_valid, if2.ser_last, if2.ser_done, if2.busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL width2 c=%0d got=%b exp=%b", c, got, exp);
            end
            tick;
        end
        if2.ser_en = 1'b0;

        w16 = 16'hBEEF;
        if16.p_data = w16; if16.load = 1'b1; if16.ser_en = 1'b1;
        tick;
        if16.load = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            exp[4] = (c <= 16) ? w16[c-1] : 1'b0;
            exp[3] = (c <= 16);
            exp[2] = (c == 16);
            exp[1] = (c == 17);
            exp[0] = (c <= 16);
            got = {if16.ser_data, if16.ser_valid, if16.ser_last, if16.ser_done, if16.busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL width16 c=%0d got=%b exp=%b", c, got, exp);
            end
            tick;
        end
        if16.ser_en = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        if8.p_data = '0;  if8.load = 1'b0;  if8.ser_en = 1'b0;
        if8m.p_data = '0; if8m.load = 1'b0; if8m.ser_en = 1'b0;
        if2.p_data = '0;  if2.load = 1'b0;  if2.ser_en = 1'b0;
        if16.p_data = '0; if16.load = 1'b0; if16.ser_en = 1'b0;

        test_reset;
        test_lsb_frame;
        test_msb_stall;
        test_back_to_back;
        test_simultaneous;
        test_reset_mid_frame;
        test_width_sweep;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_serializer.md
# param_serializer

Parametrised parallel-to-serial converter: the successor to the fixed 8-bit serializer on the UART TX path. Data width, bit order and idle line level are configurable. A one-deep holding buffer accepts the next word while the current frame shifts, so frames go out back-to-back with no gap bit. A ready/valid style handshake (`load_ready`, `ser_valid`, `ser_last`, `ser_done`) lets the TX FSM and parity/stop logic sequence against it.

## Interface
- `DATA_WIDTH`, 8: bits per frame; legal range is 2 or more.
- `MSB_FIRST`, 0: 0 shifts bit 0 first; 1 shifts bit `DATA_WIDTH-1` first.
- `IDLE_BIT`, 1'b0: level driven on `ser_data` when no frame is active.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-low reset.
- `p_data`  in  DATA_WIDTH  parallel word; sampled only on an accepted load.
- `load`  in  1  load request; accepted at a rising edge only when `load_ready`=1.
- `ser_en`  in  1  shift enable; 0 freezes the active frame.
- `load_ready`  out  1  holding buffer is empty and a load will be accepted.
- `ser_data`  out  1  serial bit.
- `ser_valid`  out  1  `ser_data` carries a data bit.
- `ser_last`  out  1  `ser_data` carries the final bit of the frame.
- `ser_done`  out  1  one-cycle pulse after the final bit is consumed.
- `busy`  out  1  a frame is active or a word is held.

## Operation
- States: IDLE, SHIFT.
- Registers:
  - `sreg[DATA_WIDTH]`, the shift register;
  - `cnt[$clog2(DATA_WIDTH)]`, counting bits consumed in the current frame;
  - `hbuf[DATA_WIDTH]` and `hvalid`, the holding buffer;
  - `ser_done`.
- `ser_data` is `sreg[0]` when `MSB_FIRST`=0 and `sreg[DATA_WIDTH-1]` when `MSB_FIRST`=1, in SHIFT; it is `IDLE_BIT` in IDLE.
- `ser_valid` = (state==SHIFT).
- `ser_last` = SHIFT && `cnt`==`DATA_WIDTH-1`.
- `busy` = SHIFT || `hvalid`.
- `load_ready` = !`hvalid`.
- No output depends combinationally on `load`, `ser_en` or `p_data`.
- IDLE, on accepted load: `sreg`<=`p_data`, `cnt`<=0, go to SHIFT. `ser_en` is ignored in IDLE.
- SHIFT with `ser_en`=1 and `cnt`<`DATA_WIDTH-1`: shift `sreg` toward the output end, `cnt`++.
- SHIFT with `ser_en`=0: `sreg` and `cnt` hold. Loads are still accepted into `hbuf`.
- SHIFT, accepted load, not at frame end: `hbuf`<=`p_data`, `hvalid`<=1.
- Frame end is SHIFT && `ser_en` && `ser_last`. On that edge `ser_done`<=1, and exactly one of the following applies:
  - if `hvalid`=1: `sreg`<=`hbuf`, `hvalid`<=0, `cnt`<=0, stay in SHIFT. A coincident `load` is not accepted, because `load_ready`=0.
  - else if `load`=1: `sreg`<=`p_data` (bypass), `cnt`<=0, stay in SHIFT.
  - else: go to IDLE.
- `ser_done` is cleared on every edge that is not a frame end.
- Reset mid-frame:
  - aborts the frame and discards `hbuf`;
  - no `ser_done` is produced;
  - `ser_data` returns to `IDLE_BIT` immediately.

## Timing
- Reset values:
  - state IDLE; `sreg`=0, `cnt`=0, `hbuf`=0, `hvalid`=0;
  - `ser_done`=0, `ser_valid`=0, `ser_last`=0, `busy`=0;
  - `load_ready`=1, `ser_data`=`IDLE_BIT`.
- Load accepted at edge k from IDLE: the first bit is on `ser_data` in cycle k+1.
- With `ser_en` held at 1:
  - bit i is presented in cycle k+1+i;
  - `ser_last` is high in cycle k+`DATA_WIDTH`;
  - `ser_done` is high in cycle k+`DATA_WIDTH`+1.
- Each `ser_en`=0 cycle inside a frame delays all later bits and `ser_done` by one cycle.
- Back-to-back frames: the first bit of the next frame appears in the same cycle as `ser_done`; `ser_valid` stays high and no gap cycle occurs.
- A held word frees `load_ready` in the cycle after the frame-end edge.
- Throughput: one bit per enabled cycle, sustained.

## Test plan
- **Reset.** `rst`=0 pulse with `load`=1 and `ser_en`=1 → all outputs at their reset values during reset; no load is accepted while `rst`=0.
- **Single LSB-first frame.** W=8, `MSB_FIRST`=0, `IDLE_BIT`=0; load 8'b10011011 with `ser_en`=1 → `ser_data` 1,1,0,1,1,0,0,1 in cycles k+1..k+8; `ser_last` only at k+8; `ser_done` one pulse at k+9; `ser_data`=0 and `busy`=0 afterwards.
- **MSB-first with stall.** `MSB_FIRST`=1, `IDLE_BIT`=1; load 8'b10011011; drop `ser_en` for 2 cycles after the 3rd bit → sequence 1,0,0,1,1,0,1,1, with the 3rd bit (0) held for 3 cycles; `ser_done` 2 cycles later than unstalled; `ser_data`=1 when idle.
- **Back-to-back via holding buffer.** Load 8'hA5, then 8'h3C at cycle k+2 → `load_ready`=0 from k+3 to k+8; 16 contiguous valid bits (A5 then 3C, LSB first); `ser_done` pulses at k+9 and k+17; `load_ready`=1 again at k+9.
- **Simultaneous events.** At the frame-end edge, `load`=1 with `hvalid`=0 → bypass, new frame starts with no gap. At the frame-end edge with `hvalid`=1 and `load`=1 → the held word is sent and `p_data` is dropped, with no corruption.
- **Reset mid-frame and width sweep.** Assert `rst` at bit 4 with a word held → IDLE immediately, no `ser_done`, the held word is lost. Repeat the single-frame check for W=2 and W=16 (16'hBEEF) → correct bit order, `ser_last` on bit W-1.
